bs_session_sched: RTL

//  Round-robin scheduler that shares the single Sync wake-up/backscatter datapath between N_REQ requesters.
//  Per granted request it drives use_stage2 and pkt_duration, issues a wake_up pulse, then tracks Sync's bs_switch.
//  bs_switch low = session started (ack); bs_switch high again = packet done. A watchdog reports sessions that never start or never finish.

---
 rtl/bs_pkg.sv | 27 ++
 rtl/bs_session_sched_rr_arbiter.sv | 40 ++++
 rtl/bs_session_sched.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/bs_pkg.sv
// Shared definitions for the backscatter session scheduler:
// state encoding, default timeout constants and the watchdog timer width.
// Imported by the scheduler top and its round-robin arbiter.
package bs_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_WAKE  = 3'd1;
  localparam state_t S_ACK   = 3'd2;
  localparam state_t S_RUN   = 3'd3;
  localparam state_t S_GUARD = 3'd4;

  localparam int DEF_DUR_W    = 32;
  localparam int DEF_WU_PULSE = 4;
  localparam int DEF_ACK_TO   = 200;
  localparam int DEF_RUN_TO   = 150000;
  localparam int DEF_GUARD    = 200;
  localparam int TIMER_W      = 32;

  // Saturating increment: a session stuck far beyond any timeout must not wrap
  // the timer back into a range where a compare could fire spuriously.
  function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] t);
    return (&t) ? t : t + 1'b1;
  endfunction

endpackage

// File: rtl/bs_session_sched_rr_arbiter.sv
// Round-robin pick: first set request bit at or after rr_ptr, wrapping.
// Purely combinational, zero latency; grant_nxt is all-zero when no request.
// No backpressure: the caller decides when to consume the pick.
module rr_arbiter
  import bs_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant_nxt,
  output logic [IDX_W-1:0] idx
);

  // Walk the requesters starting at the pointer; the first hit wins.
  always_comb begin
    logic             found;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] j;
    grant_nxt = '0;
    idx       = '0;
    found     = 1'b0;
    sum       = '0;
    j         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_REQ)) begin
        sum = sum - (IDX_W+1)'(N_REQ);
      end
      j = sum[IDX_W-1:0];
      if (!found && req[j]) begin
        found        = 1'b1;
        grant_nxt[j] = 1'b1;
        idx          = j;
      end
    end
  end

endmodule

// File: rtl/bs_session_sched.sv
// Shares the Sync wake-up/backscatter datapath between N_REQ requesters, round-robin.
// Latency: grant, wake_up and session parameters appear 1 cycle after req is seen in IDLE.
// Requesters hold req until done/err; a watchdog aborts sessions that never start or finish.
module bs_session_sched
  import bs_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DUR_W    = DEF_DUR_W,
  parameter int WU_PULSE = DEF_WU_PULSE,
  parameter int ACK_TO   = DEF_ACK_TO,
  parameter int RUN_TO   = DEF_RUN_TO,
  parameter int GUARD    = DEF_GUARD
) (
  input  logic                   clki,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*DUR_W-1:0] req_dur,
  input  logic [N_REQ-1:0]       req_stage2,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic [N_REQ-1:0]       err,
  output logic                   wake_up,
  output logic                   use_stage2,
  output logic [DUR_W-1:0]       pkt_duration,
  input  logic                   bs_switch,
  output logic                   busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [TIMER_W-1:0] WU_LAST  = TIMER_W'(WU_PULSE - 1);
  localparam logic [TIMER_W-1:0] ACK_LAST = TIMER_W'(ACK_TO - 1);
  localparam logic [TIMER_W-1:0] RUN_LAST = TIMER_W'(RUN_TO - 1);
  localparam logic [TIMER_W-1:0] GRD_LAST = TIMER_W'(GUARD - 1);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [N_REQ-1:0]   err_q, err_d;
  logic               wake_q, wake_d;
  logic               stage2_q, stage2_d;
  logic [DUR_W-1:0]   dur_q, dur_d;

  logic [N_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]   arb_idx;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .grant_nxt (arb_grant),
    .idx       (arb_idx)
  );

  // State register; reset abandons any session silently.
  always_ff @(posedge clki) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: bs_switch low acknowledges, high again completes; the timer bounds each wait.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|req) state_d = S_WAKE;
      S_WAKE:  if (timer_q == WU_LAST) state_d = S_ACK;
      S_ACK:   if (!bs_switch || timer_q == ACK_LAST) state_d = (!bs_switch) ? S_RUN : S_GUARD;
      S_RUN:   if (bs_switch || timer_q == RUN_LAST) state_d = S_GUARD;
      S_GUARD: if (timer_q == GRD_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; done/err are registered so they coincide with GUARD entry.
  always_comb begin
    timer_d  = (state_q == S_IDLE || state_d != state_q) ? '0 : sat_inc(timer_q);
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    done_d   = '0;
    err_d    = '0;
    wake_d   = wake_q;
    stage2_d = stage2_q;
    dur_d    = dur_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d  = arb_grant;
          dur_d    = req_dur[int'(arb_idx)*DUR_W +: DUR_W];
          stage2_d = req_stage2[arb_idx];
          wake_d   = 1'b1;
          rr_ptr_d = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
        end
      end
      S_WAKE: begin
        if (state_d == S_ACK) wake_d = 1'b0;
      end
      S_ACK: begin
        if (state_d == S_GUARD) err_d = grant_q;
      end
      S_RUN: begin
        if (bs_switch)               done_d = grant_q;
        else if (state_d == S_GUARD) err_d  = grant_q;
      end
      S_GUARD: begin
        if (state_d == S_IDLE) grant_d = '0;
      end
      default: begin
        grant_d = '0;
        wake_d  = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clki) begin
    if (!rst_n) begin
      timer_q  <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      wake_q   <= 1'b0;
      stage2_q <= 1'b0;
      dur_q    <= '0;
    end else begin
      timer_q  <= timer_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      err_q    <= err_d;
      wake_q   <= wake_d;
      stage2_q <= stage2_d;
      dur_q    <= dur_d;
    end
  end

  assign grant        = grant_q;
  assign done         = done_q;
  assign err          = err_q;
  assign wake_up      = wake_q;
  assign use_stage2   = stage2_q;
  assign pkt_duration = dur_q;
  assign busy         = (state_q != S_IDLE);

endmodule
